data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets address/data width of every port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cpu_req / dbg_req  input  1  per-requester access request (port 0 = CPU load/store, port 1 = debug/loader).
REQ-005 cpu_we / dbg_we  input  1  write (1) or read (0).
REQ-006 cpu_addr / dbg_addr  input  WIDTH  byte address.
REQ-007 cpu_wdata / dbg_wdata  input  WIDTH  store data.
REQ-008 cpu_mode / dbg_mode  input  3  access size code (001 word, 010 half, 011 byte, 100 unsigned half, 101 unsigned byte).
REQ-009 dbg_lock  input  1  debug requests exclusive ownership while high.
REQ-010 cpu_gnt / dbg_gnt  output  1  request accepted this cycle.
REQ-011 cpu_done / dbg_done  output  1  one-cycle pulse, cycle after acceptance.
REQ-012 cpu_rdata / dbg_rdata  output  WIDTH  read data, valid while the matching done is high.
REQ-013 mem_A, mem_WD  output  WIDTH; mem_WE  output  1; mem_modeBU  output  3  -- memory-side command.
REQ-014 mem_RD  input  WIDTH  combinational read data from memory.

Function
REQ-015 At most one grant per cycle; gnt is combinational from req, owner state and priority pointer.
REQ-016 Granted requester's addr/wdata/mode drive mem_A/mem_WD/mem_modeBU; mem_WE = granted we; no grant -> mem_WE = 0, mem_modeBU = 000, mem_A = 0.
REQ-017 Acceptance = req && gnt; on acceptance of a read, mem_RD is captured into a register at that clock edge.
REQ-018 done pulses exactly one cycle after acceptance for reads and writes; rdata holds captured value until next read completes on that port; rdata = 0 for write completions.
REQ-019 Back-to-back: a requester holding req is accepted every cycle it wins; done follows each acceptance with 1-cycle latency (throughput 1/cycle).
REQ-020 FSM states SHARED, DBG_LOCKED; SHARED -> DBG_LOCKED when dbg accepted with dbg_lock=1; DBG_LOCKED -> SHARED on first cycle dbg_lock=0.
REQ-021 In DBG_LOCKED, cpu_gnt = 0 regardless of cpu_req; dbg_gnt = dbg_req.
REQ-022 In SHARED, single requester is granted immediately; simultaneous requests resolved per REQ-027/028.
REQ-023 dbg_lock with dbg_req=0 in SHARED has no effect.
REQ-024 Priority pointer (1 bit) updates only on a contended acceptance (both req high).

Reset
REQ-025 rst_n low asynchronously: state SHARED, pointer = CPU, done = 0, rdata = 0, capture registers = 0.
REQ-026 Reset during an outstanding access discards it; no done pulse is produced after rst_n rises.

Configuration
REQ-027 Macro DATA_ARB_RR_EN defined: contended cycles granted to the pointer's requester; pointer then toggles to the other (round-robin).
REQ-028 Macro undefined: fixed priority, CPU always wins contention; pointer logic absent.

Verification
REQ-029 CPU read word addr 0x10000, mem_RD=0xDEADBEEF -> cpu_gnt same cycle, cpu_done next cycle, cpu_rdata=0xDEADBEEF.
REQ-030 Both req 4 cycles, RR_EN defined -> grants CPU,DBG,CPU,DBG; undefined -> CPU x4, dbg_gnt never high.
REQ-031 dbg write 0x12345678 to 0x10004 with dbg_lock=1, then cpu_req for 3 cycles -> mem_WE=1 mem_WD=0x12345678, cpu_gnt=0 until cycle after dbg_lock drops.
REQ-032 rst_n low one cycle after CPU read acceptance -> cpu_done stays 0, cpu_rdata=0, state SHARED.
REQ-033 No requests -> mem_WE=0, mem_modeBU=000, all gnt/done 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter: CPU (port 0) and debug/loader (port 1) share one memory.
// Optional round-robin contention policy enabled by macro DATA_ARB_RR_EN; fixed CPU priority otherwise.
module data_mem_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic [2:0]       cpu_mode,
    output logic             cpu_gnt,
    output logic             cpu_done,
    output logic [WIDTH-1:0] cpu_rdata,

    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0] dbg_wdata,
    input  logic [2:0]       dbg_mode,
    input  logic             dbg_lock,
    output logic             dbg_gnt,
    output logic             dbg_done,
    output logic [WIDTH-1:0] dbg_rdata,

    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    output logic [2:0]       mem_modeBU,
    input  logic [WIDTH-1:0] mem_RD
);

    typedef enum logic {
        SHARED     = 1'b0,
        DBG_LOCKED = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic cpu_win;
    logic dbg_win;

`ifdef DATA_ARB_RR_EN
    // Pointer: 0 = CPU owns the next contended cycle, 1 = debug does.
    logic ptr_q, ptr_d;
`endif

    logic             cpu_done_q, cpu_wr_q;
    logic             dbg_done_q, dbg_wr_q;
    logic [WIDTH-1:0] cpu_cap_q, dbg_cap_q;

    // Ownership FSM and grant decision.
    always_comb begin
        state_d = state_q;
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        case (state_q)
            SHARED: begin
                if (cpu_req && dbg_req) begin
`ifdef DATA_ARB_RR_EN
                    cpu_win = ~ptr_q;
                    dbg_win = ptr_q;
`else
                    cpu_win = 1'b1;
`endif
                end else begin
                    cpu_win = cpu_req;
                    dbg_win = dbg_req;
                end
                if (dbg_win && dbg_lock) begin
                    state_d = DBG_LOCKED;
                end
            end
            DBG_LOCKED: begin
                dbg_win = dbg_req;
                if (!dbg_lock) begin
                    state_d = SHARED;
                end
            end
            default: state_d = SHARED;
        endcase
    end

`ifdef DATA_ARB_RR_EN
    // Hand the next contended cycle to whoever lost this one.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == SHARED && cpu_req && dbg_req) begin
            ptr_d = cpu_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHARED;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory command follows the winning requester; idle bus is all zeros.
    always_comb begin
        mem_A      = '0;
        mem_WD     = '0;
        mem_WE     = 1'b0;
        mem_modeBU = 3'b000;
        if (cpu_win) begin
            mem_A      = cpu_addr;
            mem_WD     = cpu_wdata;
            mem_WE     = cpu_we;
            mem_modeBU = cpu_mode;
        end else if (dbg_win) begin
            mem_A      = dbg_addr;
            mem_WD     = dbg_wdata;
            mem_WE     = dbg_we;
            mem_modeBU = dbg_mode;
        end
    end

    // Completion tracking and read-data capture per port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_done_q <= 1'b0;
            cpu_wr_q   <= 1'b0;
            cpu_cap_q  <= '0;
            dbg_done_q <= 1'b0;
            dbg_wr_q   <= 1'b0;
            dbg_cap_q  <= '0;
        end else begin
            cpu_done_q <= cpu_win;
            cpu_wr_q   <= cpu_win & cpu_we;
            dbg_done_q <= dbg_win;
            dbg_wr_q   <= dbg_win & dbg_we;
            if (cpu_win && !cpu_we) begin
                cpu_cap_q <= mem_RD;
            end
            if (dbg_win && !dbg_we) begin
                dbg_cap_q <= mem_RD;
            end
        end
    end

    assign cpu_gnt   = cpu_win;
    assign dbg_gnt   = dbg_win;
    assign cpu_done  = cpu_done_q;
    assign dbg_done  = dbg_done_q;
    // A write completion reports zero; the last read value reappears afterwards.
    assign cpu_rdata = cpu_wr_q ? '0 : cpu_cap_q;
    assign dbg_rdata = dbg_wr_q ? '0 : dbg_cap_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter; expectations follow DATA_ARB_RR_EN.
module tb_data_mem_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             cpu_req, cpu_we, cpu_gnt, cpu_done;
    logic [WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]       cpu_mode;
    logic             dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_done;
    logic [WIDTH-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [2:0]       dbg_mode;
    logic [WIDTH-1:0] mem_A, mem_WD, mem_RD;
    logic             mem_WE;
    logic [2:0]       mem_modeBU;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic        exp_c [4];
    logic [31:0] exp_dbg_rd;

    data_mem_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_mode   (cpu_mode),
        .cpu_gnt    (cpu_gnt),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_mode   (dbg_mode),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_done   (dbg_done),
        .dbg_rdata  (dbg_rdata),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_modeBU (mem_modeBU),
        .mem_RD     (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
`ifdef DATA_ARB_RR_EN
        exp_c[0] = 1'b1; exp_c[1] = 1'b0; exp_c[2] = 1'b1; exp_c[3] = 1'b0;
        exp_dbg_rd = 32'h0000_55AA;
`else
        exp_c[0] = 1'b1; exp_c[1] = 1'b1; exp_c[2] = 1'b1; exp_c[3] = 1'b1;
        exp_dbg_rd = 32'h0;
`endif
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_mode = 3'b000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_mode = 3'b000;
        dbg_lock = 1'b0;
        mem_RD = '0;

        // Reset state
        #12;
        check_eq("rst_cpu_done", 32'(cpu_done), 32'h0);
        check_eq("rst_dbg_done", 32'(dbg_done), 32'h0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_eq("rst_mem_we", 32'(mem_WE), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single CPU word read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0000; cpu_mode = 3'b001;
        mem_RD = 32'hDEAD_BEEF;
        #2;
        check_eq("rd_cpu_gnt", 32'(cpu_gnt), 32'h1);
        check_eq("rd_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check_eq("rd_mem_A", mem_A, 32'h0001_0000);
        check_eq("rd_mem_mode", 32'(mem_modeBU), 32'h1);
        tick();
        cpu_req = 1'b0; mem_RD = 32'h0;
        check_eq("rd_cpu_done", 32'(cpu_done), 32'h1);
        check_eq("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();
        check_eq("rd_done_pulse", 32'(cpu_done), 32'h0);
        check_eq("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // Contention for four cycles
        cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0000_0200; dbg_mode = 3'b001;
        mem_RD = 32'h0000_55AA;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq($sformatf("arb%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(exp_c[i]));
            check_eq($sformatf("arb%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(!exp_c[i]));
            check_eq($sformatf("arb%0d_mem_A", i), mem_A, exp_c[i] ? 32'h100 : 32'h200);
            tick();
            check_eq($sformatf("arb%0d_cpu_done", i), 32'(cpu_done), 32'(exp_c[i]));
            check_eq($sformatf("arb%0d_dbg_done", i), 32'(dbg_done), 32'(!exp_c[i]));
        end
        check_eq("arb_dbg_rdata", dbg_rdata, exp_dbg_rd);

        // Debug locked write, CPU shut out until lock drops
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0001_0004; dbg_wdata = 32'h1234_5678;
        dbg_lock = 1'b1;
        #2;
        check_eq("lk_dbg_gnt", 32'(dbg_gnt), 32'h1);
        check_eq("lk_mem_WE", 32'(mem_WE), 32'h1);
        check_eq("lk_mem_WD", mem_WD, 32'h1234_5678);
        check_eq("lk_mem_A", mem_A, 32'h0001_0004);
        tick();
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0000;
        mem_RD = 32'h0BAD_F00D;
        check_eq("lk_dbg_done", 32'(dbg_done), 32'h1);
        check_eq("lk_dbg_rdata_wr", dbg_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            dbg_lock = (i < 2);
            #2;
            check_eq($sformatf("lk%0d_cpu_gnt", i), 32'(cpu_gnt), 32'h0);
            check_eq($sformatf("lk%0d_mem_WE", i), 32'(mem_WE), 32'h0);
            tick();
            check_eq($sformatf("lk%0d_cpu_done", i), 32'(cpu_done), 32'h0);
        end
        #2;
        check_eq("unlk_cpu_gnt", 32'(cpu_gnt), 32'h1);
        tick();
        check_eq("unlk_cpu_done", 32'(cpu_done), 32'h1);
        check_eq("unlk_cpu_rdata", cpu_rdata, 32'h0BAD_F00D);

        // Lock without a debug request changes nothing
        dbg_lock = 1'b1;
        #2;
        check_eq("lk_noreq_gnt0", 32'(cpu_gnt), 32'h1);
        tick();
        #2;
        check_eq("lk_noreq_gnt1", 32'(cpu_gnt), 32'h1);
        tick();
        dbg_lock = 1'b0;

        // CPU byte write: rdata reads zero on completion
        cpu_we = 1'b1; cpu_wdata = 32'hA5A5_A5A5; cpu_mode = 3'b011;
        #2;
        check_eq("wr_mem_WD", mem_WD, 32'hA5A5_A5A5);
        check_eq("wr_mem_mode", 32'(mem_modeBU), 32'h3);
        check_eq("wr_mem_WE", 32'(mem_WE), 32'h1);
        tick();
        check_eq("wr_cpu_done", 32'(cpu_done), 32'h1);
        check_eq("wr_cpu_rdata", cpu_rdata, 32'h0);

        // Reset during an outstanding read
        cpu_we = 1'b0; cpu_mode = 3'b001; mem_RD = 32'hCAFE_F00D;
        #2;
        check_eq("rst_rd_gnt", 32'(cpu_gnt), 32'h1);
        tick();
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_rd_done", 32'(cpu_done), 32'h0);
        check_eq("rst_rd_rdata", cpu_rdata, 32'h0);
        check_eq("rst_dbg_rdata", dbg_rdata, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_eq("rst_rel_done", 32'(cpu_done), 32'h0);
        tick();
        check_eq("rst_post_done", 32'(cpu_done), 32'h0);
        cpu_req = 1'b1;
        #2;
        check_eq("rst_shared_gnt", 32'(cpu_gnt), 32'h1);
        tick();
        cpu_req = 1'b0;
        tick();

        // Idle bus
        #2;
        check_eq("idle_mem_WE", 32'(mem_WE), 32'h0);
        check_eq("idle_mem_mode", 32'(mem_modeBU), 32'h0);
        check_eq("idle_mem_A", mem_A, 32'h0);
        check_eq("idle_cpu_gnt", 32'(cpu_gnt), 32'h0);
        check_eq("idle_dbg_gnt", 32'(dbg_gnt), 32'h0);
        tick();
        check_eq("idle_cpu_done", 32'(cpu_done), 32'h0);
        check_eq("idle_dbg_done", 32'(dbg_done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
